// File: rtl/dac_spi_multi.sv
// Multi-channel SPI DAC writer: serialises one 24-bit frame per channel, MSB first.
// Latency: cs_n falls on the edge after accept; each frame holds cs_n low 48*CLK_DIV cycles, then CS_GAP high.
// Backpressure: in_ready is high only in IDLE; samples are captured on accept and held for the whole sequence.
module dac_spi_multi #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 12,
    parameter int CLK_DIV     = 1,
    parameter int CS_GAP      = 2,
    parameter int UPDATE_MODE = 1,
    parameter int INIT_REF    = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_CH*DATA_W-1:0]   samples_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       cs_n_o,
    output logic                       sclk_o,
    output logic                       mosi_o,
    output logic                       rstn_o
);

    // Counter widths; every counter is at least one bit wide so degenerate parameters still elaborate.
    localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP  > 1) ? $clog2(CS_GAP)  : 1;

    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    // Internal reference enable command sent once after reset when INIT_REF is set.
    localparam logic [23:0] INIT_FRAME = 24'h800001;

    typedef enum logic [1:0] {
        RESET_INIT = 2'd0,
        IDLE       = 2'd1,
        SHIFT      = 2'd2,
        GAP        = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CH*DATA_W-1:0] samp_q;
    logic [23:0]              shreg_q;
    logic [4:0]               bit_q;
    logic [DIV_W-1:0]         div_q;
    logic                     phase_q;   // 0: sclk low half, 1: sclk high half
    logic [GAP_W-1:0]         gap_q;
    logic [CH_W-1:0]          ch_q;
    logic                     init_q;    // current frame is the init frame, not data
    logic                     done_q;
    logic                     rstn_q;

    logic                     accept;
    logic                     half_end;
    logic                     bit_end;
    logic                     gap_end;
    logic                     seq_last;
    logic [CH_W-1:0]          ch_nxt;

    // Build a channel frame: {cmd, addr, left-justified sample}.
    // In simultaneous-update mode only the last channel carries the update command.
    function automatic logic [23:0] build_frame(input logic [CH_W-1:0] ch,
                                                input logic [DATA_W-1:0] s);
        logic [3:0]  cmd;
        logic [15:0] d;
        d = 16'(s) << (16 - DATA_W);
        if (UPDATE_MODE == 0) begin
            cmd = 4'b0011;
        end else if (ch == CH_LAST) begin
            cmd = 4'b0010;
        end else begin
            cmd = 4'b0000;
        end
        return {cmd, 4'(ch), d};
    endfunction

    assign accept   = in_valid_i && (state_q == IDLE);
    assign half_end = (div_q == DIV_LAST);
    assign bit_end  = half_end && phase_q;
    assign gap_end  = (gap_q == GAP_LAST);
    assign seq_last = init_q || (ch_q == CH_LAST);
    assign ch_nxt   = CH_W'(ch_q + 1'b1);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RESET_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_INIT: state_d = (INIT_REF != 0) ? SHIFT : IDLE;
            IDLE:       if (accept) state_d = SHIFT;
            SHIFT:      if (bit_end && (bit_q == 5'd0)) state_d = GAP;
            GAP:        if (gap_end) state_d = seq_last ? IDLE : SHIFT;
            default:    state_d = RESET_INIT;
        endcase
    end

    // Datapath: sample capture, frame loading, bit/phase/gap counters, done pulse and DAC reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp_q  <= '0;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            gap_q   <= '0;
            ch_q    <= '0;
            init_q  <= 1'b0;
            done_q  <= 1'b0;
            rstn_q  <= 1'b0;
        end else begin
            rstn_q <= 1'b1;
            done_q <= 1'b0;
            case (state_q)
                RESET_INIT: begin
                    if (INIT_REF != 0) begin
                        shreg_q <= INIT_FRAME;
                        init_q  <= 1'b1;
                        bit_q   <= 5'd23;
                        div_q   <= '0;
                        phase_q <= 1'b0;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        samp_q  <= samples_i;
                        shreg_q <= build_frame('0, samples_i[DATA_W-1:0]);
                        ch_q    <= '0;
                        init_q  <= 1'b0;
                        bit_q   <= 5'd23;
                        div_q   <= '0;
                        phase_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_q   <= '0;
                        phase_q <= ~phase_q;
                        // mosi advances as sclk falls, so it is stable across the next rising edge
                        if (phase_q && (bit_q != 5'd0)) begin
                            shreg_q <= {shreg_q[22:0], 1'b0};
                            bit_q   <= bit_q - 5'd1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                    gap_q <= '0;
                end
                GAP: begin
                    if (gap_end) begin
                        gap_q <= '0;
                        if (seq_last) begin
                            done_q <= ~init_q;
                        end else begin
                            ch_q    <= ch_nxt;
                            shreg_q <= build_frame(ch_nxt, samp_q[int'(ch_nxt)*DATA_W +: DATA_W]);
                            bit_q   <= 5'd23;
                            div_q   <= '0;
                            phase_q <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Output decode from the current state and shift register.
    always_comb begin
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        cs_n_o     = 1'b1;
        sclk_o     = 1'b0;
        mosi_o     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
            end
            SHIFT: begin
                busy_o = 1'b1;
                cs_n_o = 1'b0;
                sclk_o = phase_q;
                mosi_o = shreg_q[23];
            end
            GAP: begin
                busy_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign done_o = done_q;
    assign rstn_o = rstn_q;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench for dac_spi_multi: default instance plus a 1-channel/16-bit/slow-clock/init-frame instance.
// Latency: frames decoded bit by bit from the SPI pins, sampled on the falling clk edge.
// Backpressure: in_valid pulsed or held high to exercise the IDLE-only handshake.
module tb_dac_spi_multi;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: NUM_CH=2, DATA_W=12, CLK_DIV=1, CS_GAP=2, UPDATE_MODE=1, INIT_REF=0
    logic        rst0, in_valid0;
    logic [23:0] samples0;
    logic        in_ready0, busy0, done0, cs_n0, sclk0, mosi0, rstn0;

    // Alternate instance: NUM_CH=1, DATA_W=16, CLK_DIV=3, CS_GAP=3, UPDATE_MODE=0, INIT_REF=1
    logic        rst1, in_valid1;
    logic [15:0] samples1;
    logic        in_ready1, busy1, done1, cs_n1, sclk1, mosi1, rstn1;

    dac_spi_multi u0 (
        .clk_i(clk), .rst_i(rst0), .samples_i(samples0), .in_valid_i(in_valid0),
        .in_ready_o(in_ready0), .busy_o(busy0), .done_o(done0), .cs_n_o(cs_n0),
        .sclk_o(sclk0), .mosi_o(mosi0), .rstn_o(rstn0)
    );

    dac_spi_multi #(
        .NUM_CH(1), .DATA_W(16), .CLK_DIV(3), .CS_GAP(3), .UPDATE_MODE(0), .INIT_REF(1)
    ) u1 (
        .clk_i(clk), .rst_i(rst1), .samples_i(samples1), .in_valid_i(in_valid1),
        .in_ready_o(in_ready1), .busy_o(busy1), .done_o(done1), .cs_n_o(cs_n1),
        .sclk_o(sclk1), .mosi_o(mosi1), .rstn_o(rstn1)
    );

    // The frame decoder watches whichever instance sel points at.
    logic sel = 1'b0;
    logic cs_n_m, sclk_m, mosi_m, in_ready_m, done_m;
    assign cs_n_m     = sel ? cs_n1     : cs_n0;
    assign sclk_m     = sel ? sclk1     : sclk0;
    assign mosi_m     = sel ? mosi1     : mosi0;
    assign in_ready_m = sel ? in_ready1 : in_ready0;
    assign done_m     = sel ? done1     : done0;

    int checks = 0;
    int errors = 0;
    int gap_bad = 0;   // sclk or mosi high while cs_n high in a gap
    int rdy_bad = 0;   // in_ready high while a frame is on the wire

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at the first sample with cs_n low; returns at the first sample with cs_n high.
    task automatic capture(output logic [23:0] f, output int low, output int bad, output int per);
        int   r1, r2;
        logic ps, pm;
        f = '0; low = 0; bad = 0; r1 = 0; r2 = 0; ps = 1'b0; pm = mosi_m;
        while (cs_n_m === 1'b0 && low < 2000) begin
            low++;
            if (in_ready_m !== 1'b0) rdy_bad++;
            if (mosi_m !== pm && sclk_m === 1'b1) bad++;
            if (sclk_m === 1'b1 && ps === 1'b0) begin
                f = {f[22:0], mosi_m};
                if (r1 == 0) r1 = low;
                else if (r2 == 0) r2 = low;
            end
            ps = sclk_m;
            pm = mosi_m;
            @(negedge clk);
        end
        per = r2 - r1;
    endtask

    // Counts cs_n-high cycles until the next frame starts or in_ready rises; counts done pulses seen.
    task automatic gap_watch(output int n, output int dn);
        n = 0; dn = 0;
        while (cs_n_m === 1'b1 && in_ready_m !== 1'b1 && n < 200) begin
            if (sclk_m !== 1'b0 || mosi_m !== 1'b0) gap_bad++;
            if (done_m === 1'b1) dn++;
            n++;
            @(negedge clk);
        end
        if (done_m === 1'b1) dn++;
    endtask

    logic [23:0] f;
    int low, bad, per, n, dn;
    int sclk_hi, done_hi, cs_lo;

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        in_valid0 = 1'b0; in_valid1 = 1'b0;
        samples0 = '0; samples1 = '0;
        repeat (3) @(negedge clk);

        // Reset values on both instances
        check("rst_outs_u0", 32'({cs_n0, sclk0, mosi0, in_ready0, busy0, done0, rstn0}), 32'h40);
        check("rst_outs_u1", 32'({cs_n1, sclk1, mosi1, in_ready1, busy1, done1, rstn1}), 32'h40);

        // Release: IDLE and rstn high one edge later
        rst0 = 1'b0;
        @(negedge clk);
        check("post_rst_u0", 32'({in_ready0, busy0, rstn0, cs_n0}), 32'hB);

        // Sequence 1: ch0=ABC ch1=123, samples altered after accept
        samples0 = {12'h123, 12'hABC};
        in_valid0 = 1'b1;
        @(negedge clk);
        check("accept_lat", 32'({cs_n0, mosi0, busy0, in_ready0}), 32'h2);
        in_valid0 = 1'b0;
        samples0 = 24'hFFFFFF;
        capture(f, low, bad, per);
        check("s1_f0", 32'(f), 32'h00ABC0);
        check("s1_f0_low", 32'(low), 32'd48);
        check("s1_f0_period", 32'(per), 32'd2);
        gap_watch(n, dn);
        check("s1_gap", 32'(n), 32'd2);
        check("s1_gap_done", 32'(dn), 32'd0);
        capture(f, low, bad, per);
        check("s1_f1", 32'(f), 32'h211230);
        check("s1_f1_low", 32'(low), 32'd48);
        gap_watch(n, dn);
        check("s1_end_gap", 32'(n), 32'd2);
        check("s1_done", 32'(dn), 32'd1);
        check("s1_idle", 32'({in_ready0, busy0}), 32'h2);
        @(negedge clk);
        check("s1_done_pulse", 32'({done0, in_ready0}), 32'h1);

        // Back-to-back sequences with in_valid held high; samples change mid-sequence
        samples0 = {12'h456, 12'h789};
        in_valid0 = 1'b1;
        @(negedge clk);
        samples0 = {12'h111, 12'h222};
        capture(f, low, bad, per);
        check("s2_f0", 32'(f), 32'h007890);
        gap_watch(n, dn);
        capture(f, low, bad, per);
        check("s2_f1", 32'(f), 32'h214560);
        gap_watch(n, dn);
        check("s2_end_gap", 32'(n), 32'd2);
        check("s2_done", 32'(dn), 32'd1);
        @(negedge clk);
        check("b2b_restart", 32'(cs_n0), 32'h0);
        in_valid0 = 1'b0;
        capture(f, low, bad, per);
        check("s3_f0", 32'(f), 32'h002220);
        check("s3_f0_bad", 32'(bad), 32'd0);
        gap_watch(n, dn);
        capture(f, low, bad, per);
        check("s3_f1", 32'(f), 32'h211110);
        gap_watch(n, dn);
        check("s3_done", 32'(dn), 32'd1);

        // Reset at bit 10 of frame 0
        samples0 = {12'hFED, 12'hCBA};
        in_valid0 = 1'b1;
        @(negedge clk);
        in_valid0 = 1'b0;
        repeat (26) @(negedge clk);
        check("bit10_in_frame", 32'({cs_n0, sclk0}), 32'h0);
        rst0 = 1'b1;
        @(negedge clk);
        check("abort_outs", 32'({cs_n0, sclk0, rstn0, done0, busy0}), 32'h10);
        sclk_hi = 0; done_hi = 0; cs_lo = 0;
        repeat (2) begin
            @(negedge clk);
            if (sclk0 !== 1'b0) sclk_hi++;
            if (done0 !== 1'b0) done_hi++;
            if (cs_n0 !== 1'b1) cs_lo++;
        end
        rst0 = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (sclk0 !== 1'b0) sclk_hi++;
            if (done0 !== 1'b0) done_hi++;
            if (cs_n0 !== 1'b1) cs_lo++;
        end
        check("abort_activity", 32'({sclk_hi[7:0], done_hi[7:0], cs_lo[7:0]}), 32'h0);
        check("abort_ready", 32'(in_ready0), 32'h1);

        // Alternate instance: init frame right after reset, then one 16-bit channel
        sel = 1'b1;
        rst1 = 1'b0;
        @(negedge clk);
        check("init_start", 32'({cs_n1, mosi1, rstn1, in_ready1, busy1}), 32'h0D);
        capture(f, low, bad, per);
        check("init_frame", 32'(f), 32'h800001);
        check("init_low", 32'(low), 32'd144);
        check("init_period", 32'(per), 32'd6);
        gap_watch(n, dn);
        check("init_gap", 32'(n), 32'd3);
        check("init_no_done", 32'(dn), 32'd0);
        check("init_ready", 32'(in_ready1), 32'h1);

        samples1 = 16'hFFFF;
        in_valid1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b0;
        samples1 = 16'h0000;
        capture(f, low, bad, per);
        check("m0_frame", 32'(f), 32'h30FFFF);
        check("m0_low", 32'(low), 32'd144);
        check("m0_mosi_stable", 32'(bad), 32'd0);
        gap_watch(n, dn);
        check("m0_gap", 32'(n), 32'd3);
        check("m0_done", 32'(dn), 32'd1);
        check("m0_ready", 32'(in_ready1), 32'h1);

        check("gap_lines", 32'(gap_bad), 32'd0);
        check("ready_in_frame", 32'(rdy_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_multi.md
DAC_SPI_MULTI -- requirements
Module: dac_spi_multi

Interface
REQ-001 Parameter NUM_CH, default 2: number of DAC channels written per update, legal range 1..8.
REQ-002 Parameter DATA_W, default 12: sample width in bits, legal range 8..16.
REQ-003 Parameter CLK_DIV, default 1: sclk half-period in clk cycles, legal value >=1.
REQ-004 Parameter CS_GAP, default 2: minimum cs_n high time between frames in clk cycles, legal value >=1.
REQ-005 Parameter UPDATE_MODE, default 1: 0 = each channel updated on its own frame; 1 = all channels loaded, then updated together on the last frame.
REQ-006 Parameter INIT_REF, default 0: 1 = send one internal-reference-enable frame after reset.
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 clk  input  1  system clock; all state changes on its rising edge.
REQ-009 rst  input  1  synchronous active-high reset.
REQ-010 samples  input  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-011 in_valid  input  1  samples valid.
REQ-012 in_ready  output  1  block can accept samples.
REQ-013 busy  output  1  high whenever not IDLE.
REQ-014 done  output  1  one-cycle pulse when an update sequence completes.
REQ-015 cs_n  output  1  SPI chip select, active low.
REQ-016 sclk  output  1  SPI clock, idles low.
REQ-017 mosi  output  1  SPI data, MSB first.
REQ-018 rstn  output  1  DAC reset, active low.

Function
REQ-019 Frame format: 24 bits = {cmd[3:0], addr[3:0], data[15:0]}; data = sample left-justified, low (16-DATA_W) bits zero.
REQ-020 Channel k uses addr = k; channels are sent in ascending order, starting at 0.
REQ-021 UPDATE_MODE=0: cmd = 4'b0011 for every channel.
REQ-022 UPDATE_MODE=1: cmd = 4'b0000 for channels 0..NUM_CH-2 and 4'b0010 for channel NUM_CH-1; NUM_CH=1 sends a single frame with 4'b0010.
REQ-023 Init frame (INIT_REF=1 only) = 24'h800001.
REQ-024 FSM states: RESET_INIT, IDLE, SHIFT, GAP.
- IDLE -> SHIFT on accept.
- SHIFT -> GAP after bit 0.
- GAP -> SHIFT (next channel) or -> IDLE (last channel, or after init frame).
REQ-025 Handshake: in_ready = 1 only in IDLE; accept = in_valid & in_ready; samples are captured on accept and later changes to samples are ignored.
REQ-026 Latency: cs_n falls on the clock edge following accept, with mosi = bit 23 in the same cycle.
REQ-027 Bit timing: each bit lasts 2*CLK_DIV cycles (sclk low for CLK_DIV cycles, then high for CLK_DIV cycles); mosi changes only while sclk is low, so it is stable at the sclk rising edge.
REQ-028 cs_n is low for exactly 48*CLK_DIV cycles per frame, and sclk is low when cs_n rises.
REQ-029 GAP: cs_n high, sclk low, mosi 0 for exactly CS_GAP cycles.
REQ-030 done pulses on the cycle the FSM enters IDLE after a data sequence; in_ready rises in that same cycle; the init frame does not pulse done.
REQ-031 in_valid held high continuously: back-to-back sequences separated by exactly 1 IDLE cycle plus CS_GAP.
REQ-032 busy = ~in_ready, except during reset.

Reset
REQ-033 While rst is high: cs_n=1, sclk=0, mosi=0, in_ready=0, busy=0, done=0, rstn=0.
REQ-034 rstn goes high 1 cycle after rst deasserts.
REQ-035 After reset with INIT_REF=1: the init frame starts 1 cycle after rst deasserts, and IDLE is entered after its GAP.
REQ-036 After reset with INIT_REF=0: IDLE is entered 1 cycle after rst deasserts.
REQ-037 Reset asserted mid-frame aborts the frame: cs_n=1 on the next edge, captured samples are discarded, and no done pulse is produced.

Verification
REQ-038 Default parameters, ch0=0xABC, ch1=0x123 -> frames 24'h00ABC0 then 24'h211230, cs_n low 48 cycles each, gap 2 cycles, one done pulse.
REQ-039 UPDATE_MODE=0, NUM_CH=1, DATA_W=16, sample 0xFFFF -> single frame 24'h30FFFF, done pulse, in_ready=1.
REQ-040 CLK_DIV=3 -> sclk period 6 cycles, cs_n low 144 cycles, mosi transitions only while sclk=0.
REQ-041 INIT_REF=1 -> 24'h800001 sent after reset, in_ready low until after it, no done pulse.
REQ-042 rst asserted at bit 10 of frame 0 -> cs_n=1 on the next edge, rstn=0, no further sclk edges, no done pulse.
REQ-043 in_valid held high, samples changed mid-sequence -> frames use the accepted values; the next accept occurs exactly 1+CS_GAP cycles after the previous frame's cs_n rises.
